// File: rtl/t05_pkg.sv
// Shared types and constants for the serial-to-byte packer.
package t05_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    PAD,
    DRAIN,
    DONE
  } packer_state_t;

endpackage

// File: rtl/t05_byte_fifo.sv
// Show-ahead synchronous FIFO: rd_data always presents the head entry.
module t05_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign empty   = (r_count == '0);
  assign full    = (r_count == FULL_CNT);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];

  // A pop in the same cycle frees a slot, so a push at full still lands.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/t05_bit_packer.sv
// Packs a 1-bit serial stream MSB-first into bytes, buffers them, and on flush
// zero-pads the last partial byte, drains the FIFO and pulses flush_done.
module t05_bit_packer
  import t05_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              flush,
  input  logic              byte_ready,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  output logic              busy,
  output logic              flush_done,
  output logic              overflow,
  output logic              proto_err,
  output logic [CNT_W-1:0]  total_bits,
  output packer_state_t     dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);

  packer_state_t     r_state;
  logic [BYTE_W-1:0] r_sh;
  logic [2:0]        r_bit_cnt;
  logic [CNT_W-1:0]  r_total;
  logic              r_busy;
  logic              r_flush_done;
  logic              r_overflow;
  logic              r_proto_err;

  logic              w_full;
  logic              w_empty;
  logic [AW:0]       w_count;
  logic              w_pop;
  logic              w_accept;
  logic              w_byte_done;
  logic              w_space;
  logic              w_push;
  logic [BYTE_W-1:0] w_push_data;
  logic [BYTE_W-1:0] w_pad;
  logic [3:0]        w_shamt;
  logic [2:0]        w_cnt_after;

  // Downstream handshake: byte_valid means byte_out holds the FIFO head; a byte
  // transfers on each clock edge where byte_valid && byte_ready are both high.
  assign byte_valid = !w_empty;
  assign w_pop      = byte_valid && byte_ready;

  always_comb begin
    w_accept    = bit_valid && (r_state == IDLE || r_state == COLLECT);
    w_byte_done = w_accept && (r_bit_cnt == 3'd7);
    w_space     = !w_full || w_pop;
    w_cnt_after = r_bit_cnt + {2'b00, w_accept};
    w_shamt     = 4'd8 - {1'b0, r_bit_cnt};
    w_pad       = r_sh << w_shamt;
    w_push      = (w_byte_done || r_state == PAD) && w_space;
    w_push_data = (r_state == PAD) ? w_pad : {r_sh[6:0], bit_in};
  end

  t05_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (BYTE_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .rd_data   (byte_out),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sh         <= '0;
      r_bit_cnt    <= '0;
      r_total      <= '0;
      r_busy       <= 1'b0;
      r_flush_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      if (w_accept) begin
        r_sh      <= {r_sh[6:0], bit_in};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_total   <= r_total + 1'b1;
        if (w_byte_done && !w_space) begin
          r_overflow <= 1'b1;
        end
      end
      case (r_state)
        IDLE, COLLECT: begin
          // A bit arriving with flush is counted before the pad decision.
          if (flush) begin
            r_busy <= 1'b1;
            if (r_state == IDLE && !w_accept) begin
              r_state      <= DONE;
              r_flush_done <= 1'b1;
            end else if (w_cnt_after != 3'd0) begin
              r_state <= PAD;
            end else begin
              r_state <= DRAIN;
            end
          end else if (w_accept) begin
            r_state <= COLLECT;
            r_busy  <= 1'b1;
          end
        end
        PAD: begin
          if (bit_valid) r_proto_err <= 1'b1;
          if (w_space) begin
            r_bit_cnt <= '0;
            r_state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (bit_valid) r_proto_err <= 1'b1;
          if (w_count == '0) begin
            r_state      <= DONE;
            r_flush_done <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_total <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign flush_done = r_flush_done;
  assign overflow   = r_overflow;
  assign proto_err  = r_proto_err;
  assign total_bits = r_total;
  assign dbg_state  = r_state;

endmodule

// File: doc/t05_bit_packer.md
Name: t05_bit_packer

Overview:
- Sits directly downstream of the header-synthesis and code-path serialisers in the compression datapath.
- Consumes their 1-bit serial stream (bit strobe plus data bit) and packs it MSB-first into bytes.
- Buffers the bytes in a small FIFO and hands them to the byte writer (SRAM/SPI) over a valid/ready handshake.
- On end-of-stream, zero-pads the final partial byte, drains, and signals completion.

Parameters:
- FIFO_DEPTH, 4, byte FIFO entries; power of two, at least 2.
- CNT_W, 24, width of the total-bit counter.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- bit_valid  input  1  upstream strobe; bit_in is accepted on every cycle it is high
- bit_in  input  1  serial data bit, MSB of each byte first
- flush  input  1  single-cycle end-of-stream request
- byte_ready  input  1  downstream accepts byte_out this cycle
- byte_out  output  8  FIFO head byte
- byte_valid  output  1  FIFO non-empty
- busy  output  1  high whenever state is not IDLE
- flush_done  output  1  one-cycle pulse once the stream is fully drained
- overflow  output  1  sticky; a completed byte was dropped because the FIFO was full
- proto_err  output  1  sticky; bit_valid was asserted during PAD or DRAIN
- total_bits  output  CNT_W  count of accepted data bits, excluding padding

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high, ports named clk and rst.
- Reset values: shift register 0, bit_cnt 0, FIFO pointers and count 0, byte_out 0, byte_valid 0, busy 0, flush_done 0, overflow 0, proto_err 0, total_bits 0, state IDLE.
- Reset mid-operation discards all buffered data; no flush_done is emitted.
- Upstream has no backpressure; every bit_valid cycle must be consumed or flagged.
- Shift rule: each accepted bit performs sh <= {sh[6:0], bit_in}, bit_cnt+1, total_bits+1.
- total_bits wraps modulo 2^CNT_W.
- Byte completion: when bit_cnt is 7 and a bit is accepted, {sh[6:0], bit_in} is pushed at that edge and bit_cnt becomes 0.
  - If the FIFO is full at that edge (pop in the same cycle counts as space), the byte is dropped and overflow is set.
- FIFO: show-ahead. byte_out is the head entry; byte_valid = (count != 0). A pop occurs when byte_valid && byte_ready.
  - Simultaneous push and pop at full is legal; count is unchanged.
  - Latency: a byte completed at edge N is visible on byte_out/byte_valid after edge N if the FIFO was empty.
- State machine:
  - IDLE: first bit_valid moves to COLLECT (the bit is accepted that cycle). flush in IDLE with nothing pending moves directly to DONE.
  - COLLECT: accepts bits. On flush, go to PAD if bit_cnt != 0, otherwise DRAIN.
    - If bit_valid and flush are high together, the bit is accepted first, then the flush evaluates the updated bit_cnt.
  - PAD: pushes {sh << (8 - bit_cnt)} (zero-filled LSBs) in one cycle, sets bit_cnt to 0, then goes to DRAIN.
    - If the FIFO is full, PAD holds until space exists; no drop occurs.
  - DRAIN: waits for FIFO count to reach 0, then goes to DONE.
  - DONE: asserts flush_done for exactly one cycle, returns to IDLE, and clears total_bits.
- In PAD or DRAIN, bit_valid sets proto_err and the bit is ignored.
- A flush received while in PAD, DRAIN or DONE is ignored.
- overflow and proto_err clear only on reset.

Decomposition:
- t05_pkg holds:
  - packer_state_t enum (IDLE, COLLECT, PAD, DRAIN, DONE)
  - BYTE_W = 8
- Natural sub-module: t05_byte_fifo, a parameterised show-ahead synchronous FIFO with push, pop, full, empty and count.
- The packer FSM, shift register and counters stay in the top module.

Test Plan:
- Stream bits 1,0,1,1,0,0,1,0 with byte_ready=1 -> byte_out=8'hB2, byte_valid high for 1 cycle, total_bits=8.
- Stream bits 1,1,1 then flush -> PAD pushes 8'hE0, then flush_done pulses once; total_bits reads 3 before DONE and 0 after.
- byte_ready=0, stream 40 continuous bits with FIFO_DEPTH=4 -> 4 bytes held, 5th byte dropped, overflow=1.
  - Then raise byte_ready -> the 4 original bytes emerge in order.
- Assert bit_valid and flush together on the 16th bit -> both bytes emitted, no PAD byte, flush_done after the FIFO empties.
- bit_valid asserted during DRAIN -> proto_err=1, bit ignored, output bytes unchanged.
- Assert rst mid-COLLECT with 2 bytes queued -> all outputs return to reset values immediately (asynchronously); no flush_done.
  - Subsequent stream 8'h5A packs correctly.
